// File: rtl/rv_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// rv_muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide sequencer:
//   - funct3 encodings of the eight M-extension operations
//   - sequencer state encoding
//   - helpers telling which operands an operation treats as signed
// ---------------------------------------------------------------------------
package rv_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV and REM (MULHSU keeps it unsigned).
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/rv_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// rv_muldiv_seq_if
// Request/response bundle between the core (master) and the multiply/divide
// sequencer (slave).
//   flush       core -> seq   abandon any op in flight
//   req_valid   core -> seq   request present
//   req_ready   seq  -> core  sequencer idle, request can be taken
//   funct3      core -> seq   M-extension operation select
//   op_a, op_b  core -> seq   rs1 / rs2 values
//   resp_valid  seq  -> core  result valid, held until resp_ready
//   resp_ready  core -> seq   result consumed
//   result      seq  -> core  rd value
//   busy        seq  -> core  operation in progress
// ---------------------------------------------------------------------------
interface rv_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, req_valid, funct3, op_a, op_b, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  flush, req_valid, funct3, op_a, op_b, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the sequencer datapath.
//   is_div     in   1       0: shift-add multiply step, 1: restoring divide step
//   work       in   2*XLEN  multiply: {partial high, partial low/multiplier}
//                           divide:   {partial remainder, dividend/quotient}
//   opnd       in   XLEN    multiplicand (multiply) or divisor (divide)
//   work_next  out  2*XLEN  work register after this iteration
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] work,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] work_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        // NOTE: every combinational output gets a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        work_next = work;

        // Multiply: conditional add into the high half, keeping the carry,
        // then shift the whole register right by one.
        sum = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);

        // Divide: shift the next dividend bit into the remainder and try a
        // subtract; a borrow out of bit XLEN means the divisor did not fit.
        trial = {work[2*XLEN-1:XLEN], work[XLEN-1]};
        diff  = trial - {1'b0, opnd};

        if (is_div) begin
            if (diff[XLEN]) begin
                work_next = {trial[XLEN-1:0], work[XLEN-2:0], 1'b0};
            end else begin
                work_next = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
            end
        end else begin
            work_next = {sum, work[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/rv_muldiv_seq.sv
// ---------------------------------------------------------------------------
// rv_muldiv_seq
// Iterative RV32M multiply/divide sequencer. One op is accepted in IDLE, run
// as XLEN radix-2 iterations on operand magnitudes (CALC), sign corrected and
// registered (FIX), then held in DONE until the consumer takes it.
//   clk, rst   clock, asynchronous active-high reset
//   bus        rv_muldiv_seq_if.slave request/response bundle
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as
// the remaining multiplier bits are zero, with the product pre-aligned by the
// skipped shift count so results are unchanged.
// ---------------------------------------------------------------------------
module rv_muldiv_seq
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    rv_muldiv_seq_if.slave bus
);
    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3_q;
    logic                res_neg;
    logic [2*XLEN-1:0]   work;
    logic [2*XLEN-1:0]   work_step;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                sa;
    logic                sb;
    logic                div0;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                last_iter;
    logic                early_out;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_or_rem;
    logic [XLEN-1:0]     div_fix;
    logic [XLEN-1:0]     result_fix;

    // flush wins over a same-cycle request.
    assign accept = bus.req_valid && (state == S_IDLE) && !bus.flush;

    assign sa    = is_signed_a(bus.funct3) && bus.op_a[XLEN-1];
    assign sb    = is_signed_b(bus.funct3) && bus.op_b[XLEN-1];
    assign mag_a = sa ? -bus.op_a : bus.op_a;
    assign mag_b = sb ? -bus.op_b : bus.op_b;
    assign div0  = bus.funct3[2] && (bus.op_b == '0);

    assign last_iter = (cnt == CNT_W'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
    // After cnt steps only the low XLEN-cnt bits still hold multiplier bits.
    logic [XLEN-1:0] live_mask;
    assign live_mask = {XLEN{1'b1}} >> cnt;
    assign early_out = !f3_q[2] && ((work[XLEN-1:0] & live_mask) == '0);
`else
    assign early_out = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div    (f3_q[2]),
        .work      (work),
        .opnd      (opnd),
        .work_next (work_step)
    );

    // Sign correction: product negated as a whole 2*XLEN value; divide
    // negates whichever half (quotient or remainder) the op returns.
    assign prod_fix   = res_neg ? -work : work;
    assign quo_or_rem = f3_q[1] ? work[2*XLEN-1:XLEN] : work[XLEN-1:0];
    assign div_fix    = res_neg ? -quo_or_rem : quo_or_rem;
    assign result_fix = f3_q[2]             ? div_fix :
                        (f3_q == F3_MUL)    ? prod_fix[XLEN-1:0] :
                                              prod_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = div0 ? S_FIX : S_CALC;
            S_CALC: if (early_out || last_iter) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (bus.resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.flush) state_next = S_IDLE;
    end

    // NOTE: the datapath registers are reset too, so a reset mid-op leaves
    // no partial product or quotient that could ever reach result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            res_neg  <= 1'b0;
            work     <= '0;
            opnd     <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt  <= '0;
                        f3_q <= bus.funct3;
                        opnd <= bus.funct3[2] ? mag_b : mag_a;
                        if (!bus.funct3[2]) begin
                            work    <= {{XLEN{1'b0}}, mag_b};
                            res_neg <= sa ^ sb;
                        end else if (div0) begin
                            // Quotient all ones; remainder |a| re-signed to a.
                            work    <= {mag_a, {XLEN{1'b1}}};
                            res_neg <= bus.funct3[1] ? sa : 1'b0;
                        end else begin
                            work    <= {{XLEN{1'b0}}, mag_a};
                            res_neg <= bus.funct3[1] ? sa : (sa ^ sb);
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        cnt  <= cnt + CNT_W'(1);
                        // Early exit: the remaining steps would only shift.
                        work <= early_out ? (work >> (XLEN - int'(cnt))) : work_step;
                    end
                end
                S_FIX: begin
                    if (!bus.flush) result_q <= result_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_DONE);
    assign bus.busy       = (state == S_CALC) || (state == S_FIX);
    assign bus.result     = result_q;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_rv_muldiv_seq
// Directed and randomized checks of rv_muldiv_seq against a plain-arithmetic
// 64-bit reference model of the RV32M operations.
// ---------------------------------------------------------------------------
module tb_rv_muldiv_seq;
    import rv_muldiv_pkg::*;

    localparam int XLEN    = 32;
    localparam int FULL_LAT = XLEN + 2;
    localparam int MAX_WAIT = 100;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] last_res;

    rv_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    rv_muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed in 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            F3_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            F3_REM:    begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
            default:   begin if (b == 0) return a;             p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Cycle (accept = 0) at which resp_valid is expected.
    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2]) begin
            logic [31:0] m;
            int k;
            m = (f3 < 3'd2 && b[31]) ? -b : b;
            k = 0;
            while (m != 0) begin
                m = m >> 1;
                k++;
            end
            return (k + 3 < FULL_LAT) ? k + 3 : FULL_LAT;
        end
`endif
        return FULL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for the response, optionally stall the consumer for
    // `hold` cycles (with a competing request present), then consume it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < MAX_WAIT) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) begin
            check({tag, "_timeout"}, 32'(bus.resp_valid), 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(n + 1), 32'(exp_latency(f3, b)));
            check({tag, "_result"}, bus.result, exp);
        end
        last_res = exp;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.funct3    = F3_MUL;
            bus.op_a      = 32'd3;
            bus.op_b      = 32'd3;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_result"}, bus.result, exp);
            check({tag, "_hold_resp_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, "_release_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_release_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_result"}, bus.result, 32'd0);
    endtask

    initial begin
        int seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        errors = 0;
        checks = 0;
        last_res = '0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.funct3 = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Multiply family.
        run_op("mul_7_m3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulh_7_m3",     F3_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_op("mulhu_max",     F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu_m1_2",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);

        // Divide family.
        run_op("div_m7_2",      F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_op("rem_m7_2",      F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu_100_7",    F3_DIVU,   32'd100,       32'd7,         32'd14,        0);
        run_op("remu_100_7",    F3_REMU,   32'd100,       32'd7,         32'd2,         0);

        // Divide by zero and signed overflow.
        run_op("div_5_0",       F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_5_0",       F3_REM,    32'd5,         32'd0,         32'd5,         0);
        run_op("div_ovf",       F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",       F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

        // Consumer stall for 10 cycles.
        run_op("stall_divu",    F3_DIVU,   32'd100,       32'd7,         32'd14,        10);

        // flush beats a same-cycle request.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.funct3    = F3_DIVU;
        bus.op_a      = 32'd50;
        bus.op_b      = 32'd5;
        bus.flush     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_vs_req_busy", 32'(bus.busy), 32'd0);
        check("flush_vs_req_ready", 32'(bus.req_ready), 32'd1);

        // flush in CALC cycle 5.
        bus.req_valid = 1'b1;
        bus.funct3    = F3_DIVU;
        bus.op_a      = 32'hFFFF_FFF0;
        bus.op_b      = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_calc_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_req_ready", 32'(bus.req_ready), 32'd1);
        check("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_result_kept", bus.result, last_res);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        run_op("after_flush_divu", F3_DIVU, 32'd9, 32'd3, 32'd3, 0);

        // Reset pulse in CALC cycle 12.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.funct3    = F3_MULHU;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_after");
        run_op("after_rst_mulhu", F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_model(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
